// File: rtl/fp_expand_stream_if.sv
// Valid/ready stream bundle. The producer side uses the master modport and the
// consumer side uses the slave modport. W sets the payload width.
interface fp_expand_stream_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface : fp_expand_stream_if

// File: rtl/fp_expand_stream.sv
// Float-code expander: buffers 8-bit {sign, exp[2:0], sig[3:0]} codes in a
// small FIFO and turns each one into a 12-bit two's-complement linear sample.
// The sample sits in a back-pressurable output register.
// in_if carries 8-bit codes (slave side). out_if carries 12-bit samples
// (master side).
module fp_expand_stream #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_expand_stream_if.slave    in_if,
    fp_expand_stream_if.master   out_if,
    output logic [15:0]          xfer_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Expand one code: magnitude = sig << exp (at most 1920, so it fits in
    // 11 bits). A negative sign negates in 12 bits. Negative zero comes out
    // as 0 because 0 - 0 = 0.
    function automatic logic [11:0] decode(input logic [7:0] c);
        logic [10:0] mag;
        mag = 11'(c[3:0]) << c[6:4];
        if (c[7]) begin
            decode = 12'd0 - {1'b0, mag};
        end else begin
            decode = {1'b0, mag};
        end
    endfunction

    // FIFO storage. Reads are asynchronous so that the head can be decoded
    // straight into the output register. This keeps input-to-output latency
    // at two cycles.
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    // Output register and delivery counter.
    logic          out_valid_q,  out_valid_d;
    logic [11:0]   out_sample_q, out_sample_d;
    logic [15:0]   xfer_q,       xfer_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          out_fire;
    logic [11:0]   head_dec;

    // in_ready depends only on the registered count, so there is no
    // combinational path from either in_valid or out_ready.
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = in_if.valid && !fifo_full;
    assign out_fire   = out_valid_q && out_if.ready;
    assign pop        = !fifo_empty && (!out_valid_q || out_if.ready);
    assign head_dec   = decode(mem_q[rd_ptr_q]);

    assign in_if.ready  = !fifo_full;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = out_sample_q;
    assign xfer_count   = xfer_q;

    // Next-state logic for the pointers, the occupancy count, the output
    // register and the delivery counter.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_sample_d = out_sample_q;
        xfer_d       = xfer_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Refill the output register whenever the FIFO has a code and the
        // register is empty or is being handed over this cycle.
        if (pop) begin
            out_valid_d  = 1'b1;
            out_sample_d = head_dec;
        end else if (out_fire) begin
            out_valid_d  = 1'b0;
        end

        if (out_fire) begin
            xfer_d = xfer_q + 16'd1;
        end
    end

    // Control state register. Reset discards buffered codes and blocks any
    // handshake that happens in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= 12'h000;
            xfer_q       <= 16'h0000;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            xfer_q       <= xfer_d;
        end
    end

    // FIFO write port. The storage is not reset; the pointers decide what is
    // live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= in_if.data;
        end
    end

endmodule : fp_expand_stream

// File: tb/tb_fp_expand_stream.sv
// Self-checking bench for fp_expand_stream. It uses a table of decode
// vectors, hand sequences for latency, backpressure and reset, and random
// traffic. A negedge monitor compares every delivered sample against a queue
// that is decoded arithmetically.
module tb_fp_expand_stream;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] xfer_count;

    fp_expand_stream_if #(.W(8))  in_s ();
    fp_expand_stream_if #(.W(12)) out_s ();

    fp_expand_stream #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (in_s),
        .out_if     (out_s),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference decode. The linear value is sig * 2^exp, negated when the
    // sign bit is set.
    function automatic logic [11:0] ref_decode(input logic [7:0] c);
        int v;
        v = int'(c[3:0]) * (1 << int'(c[6:4]));
        if (c[7]) v = -v;
        return v[11:0];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard state owned by the monitor.
    logic [11:0] exp_q[$];
    logic [15:0] exp_xfer   = 16'h0;
    logic        prev_stall = 1'b0;
    logic [11:0] prev_sample = 12'h0;

    // Monitor: samples at the negedge, which is the value seen by the next
    // rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_xfer   = 16'h0;
            prev_stall = 1'b0;
        end else begin
            // Items held = FIFO + output register. The input side is full
            // exactly when DEPTH+1 items are held.
            check("in_ready_occupancy", int'(in_s.ready), int'(exp_q.size() != DEPTH + 1));
            check("xfer_count_track", int'(xfer_count), int'(exp_xfer));
            if (prev_stall) begin
                check("hold_valid", int'(out_s.valid), 1);
                check("hold_sample", int'(out_s.data), int'(prev_sample));
            end
            if (out_s.valid && out_s.ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 1, 0);
                end else begin
                    check("sample_order", int'(out_s.data), int'(exp_q.pop_front()));
                end
                exp_xfer = exp_xfer + 16'd1;
            end
            if (in_s.valid && in_s.ready) begin
                exp_q.push_back(ref_decode(in_s.data));
            end
            prev_stall  = out_s.valid && !out_s.ready;
            prev_sample = out_s.data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        in_s.valid  = 1'b0;
        out_s.ready = 1'b1;
        n = 0;
        while ((out_s.valid || exp_q.size() != 0) && n < 64) begin
            tick();
            n++;
        end
        check("drain_done", int'(out_s.valid || exp_q.size() != 0), 0);
    endtask

    task automatic stream(input int n);
        out_s.ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_s.valid = 1'b1;
            in_s.data  = 8'($urandom);
            tick();
        end
        in_s.valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  code;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int          n_acc;
        int          cyc;
        logic        acc;
        logic        hs;
        logic [15:0] start;
        int          remaining;

        tbl[0] = '{8'h00, 12'h000};
        tbl[1] = '{8'h2A, 12'h028};
        tbl[2] = '{8'hB5, 12'hFD8};
        tbl[3] = '{8'h7F, 12'h780};
        tbl[4] = '{8'hFF, 12'h880};
        tbl[5] = '{8'h80, 12'h000};
        tbl[6] = '{8'h31, 12'h008};
        tbl[7] = '{8'hCF, 12'hF10};
        tbl[8] = '{8'h10, 12'h000};

        rst         = 1'b1;
        in_s.valid  = 1'b0;
        in_s.data   = 8'h00;
        out_s.ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state.
        check("rst_out_valid", int'(out_s.valid), 0);
        check("rst_out_sample", int'(out_s.data), 0);
        check("rst_xfer", int'(xfer_count), 0);
        check("rst_in_ready", int'(in_s.ready), 1);

        // Decode sweep, one code at a time, with latency checks.
        out_s.ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_s.valid = 1'b1;
            in_s.data  = tbl[i].code;
            check("sweep_in_ready", int'(in_s.ready), 1);
            tick();
            in_s.valid = 1'b0;
            check("sweep_lat1_valid", int'(out_s.valid), 0);
            tick();
            check("sweep_lat2_valid", int'(out_s.valid), 1);
            check("sweep_sample", int'(out_s.data), int'(tbl[i].exp));
            tick();
            check("sweep_consumed", int'(out_s.valid), 0);
        end
        drain();

        // Backpressure: keep offering 0x01..0x06 while the sink is stalled.
        out_s.ready = 1'b0;
        in_s.valid  = 1'b1;
        in_s.data   = 8'h01;
        n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            acc = in_s.ready;
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc == 5) check("bp_ready_low_after5", int'(in_s.ready), 0);
                in_s.data = 8'(n_acc + 1);
            end
        end
        check("bp_accepted", n_acc, 5);
        check("bp_in_ready", int'(in_s.ready), 0);
        check("bp_out_valid", int'(out_s.valid), 1);
        check("bp_hold_sample", int'(out_s.data), 12'h001);
        out_s.ready = 1'b1;
        tick();
        check("bp_drain_2", int'(out_s.data), 2);
        check("bp_ready_rise", int'(in_s.ready), 1);
        tick();
        check("bp_drain_3", int'(out_s.data), 3);
        in_s.valid = 1'b0;
        for (int i = 4; i <= 6; i++) begin
            tick();
            check("bp_drain_seq_valid", int'(out_s.valid), 1);
            check("bp_drain_seq", int'(out_s.data), i);
        end
        drain();

        // Mid-stream reset with three codes held and the output valid.
        out_s.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_s.valid = 1'b1;
            in_s.data  = 8'(8'h11 * (i + 1));
            tick();
        end
        check("mrst_pre_valid", int'(out_s.valid), 1);
        rst         = 1'b1;
        in_s.valid  = 1'b1;
        in_s.data   = 8'h44;
        out_s.ready = 1'b1;
        tick();
        rst         = 1'b0;
        in_s.valid  = 1'b0;
        out_s.ready = 1'b0;
        check("mrst_out_valid", int'(out_s.valid), 0);
        check("mrst_out_sample", int'(out_s.data), 0);
        check("mrst_xfer", int'(xfer_count), 0);
        check("mrst_in_ready", int'(in_s.ready), 1);
        out_s.ready = 1'b1;
        in_s.valid  = 1'b1;
        in_s.data   = 8'h2A;
        tick();
        in_s.valid = 1'b0;
        tick();
        check("mrst_first_valid", int'(out_s.valid), 1);
        check("mrst_first_sample", int'(out_s.data), 12'h028);
        drain();

        // Exhaustive: stream all 256 codes back to back.
        start = exp_xfer;
        out_s.ready = 1'b1;
        for (int c = 0; c < 256; c++) begin
            in_s.valid = 1'b1;
            in_s.data  = 8'(c);
            check("exh_in_ready", int'(in_s.ready), 1);
            tick();
        end
        in_s.valid = 1'b0;
        drain();
        check("exh_xfer", int'(xfer_count), int'(16'(start + 16'd256)));

        // Random valid/ready traffic. The source holds its code while stalled.
        n_acc = 0;
        cyc   = 0;
        in_s.valid = 1'b0;
        while (n_acc < 10000 && cyc < 40000) begin
            hs = in_s.valid && in_s.ready;
            tick();
            cyc++;
            if (hs) n_acc++;
            if (!(in_s.valid && !hs)) begin
                in_s.valid = ($urandom_range(0, 99) < 75);
                in_s.data  = 8'($urandom);
            end
            out_s.ready = ($urandom_range(0, 99) < 75);
        end
        check("rand_accepted_enough", int'(n_acc >= 10000), 1);
        drain();
        check("rand_xfer", int'(xfer_count), int'(exp_xfer));

        // Wrap: bring the counter to 0xFFFF, then two more transfers.
        remaining = 65535 - int'(exp_xfer);
        stream(remaining);
        drain();
        check("wrap_ffff", int'(xfer_count), 16'hFFFF);
        stream(2);
        drain();
        check("wrap_0001", int'(xfer_count), 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fp_expand_stream

// File: doc/fp_expand_stream.md
# fp_expand_stream

Streaming expander that sits directly downstream of the linear-to-float converter. It accepts 8-bit compressed floating-point codes (sign, 3-bit exponent, 4-bit significand) over a valid/ready handshake and buffers them in a small FIFO. It expands each code back to a 12-bit two's-complement linear sample on a registered, back-pressurable output. It also counts delivered samples for debug and throughput checks.

## Interface
- DEPTH, 4, FIFO entries ahead of the output register; power of two, ≥2
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_code is valid this cycle
- in_ready  output  1  block can accept in_code this cycle
- in_code  input  8  [7]=sign, [6:4]=exponent, [3:0]=significand
- out_valid  output  1  out_sample is valid
- out_ready  input  1  consumer accepts out_sample this cycle
- out_sample  output  12  expanded linear sample, two's complement
- xfer_count  output  16  number of completed output handshakes, wraps

## Operation
- Input transfer: in_valid && in_ready at a rising edge; the code is written to the FIFO tail.
- in_ready = (fifo_count != DEPTH). It is driven from registered state only and has no combinational path from out_ready or in_valid.
- Output register (out_valid, out_sample) loads the decoded FIFO head when the FIFO is non-empty and (!out_valid || out_ready). The head is popped in the same edge.
- Decode of code {s, e[2:0], m[3:0]}:
  - mag = m << e, zero-extended to 11 bits. Maximum is 15<<7 = 1920, so no overflow is possible.
  - s=0: out_sample = {1'b0, mag}.
  - s=1: out_sample = -{1'b0, mag} in 12-bit two's complement.
  - Negative zero (s=1, mag=0) yields 0x000.
  - Output range is −1920..+1920; −2048 is never produced.
- Output handshake: out_valid && out_ready at an edge; xfer_count increments by 1 and wraps 0xFFFF→0x0000.
- out_sample holds stable while out_valid && !out_ready.
- Ordering: strict FIFO order; no drops, no duplicates.
- FIFO count rules:
  - Simultaneous push and pop: count unchanged.
  - Push only: count +1.
  - Pop only: count −1.
- Full: in_ready=0. An in_valid while full is ignored (not an error) and the upstream holds the code.
- Empty with the output register drained: out_valid=0. out_sample keeps its last value and is don't-care to the consumer.
- Reset (synchronous, also mid-stream):
  - FIFO contents are discarded and fifo_count=0.
  - out_valid=0, out_sample=0x000, xfer_count=0.
  - in_ready=1 from the first cycle after the reset edge.
  - A handshake on either port in the reset cycle is ignored.

## Timing
- Latency: a code accepted at edge k appears with out_valid=1 after edge k+1 when the FIFO is empty and the output register is empty or being drained. This is 2 cycles from in_valid to out_valid.
- Throughput: 1 code/cycle sustained while out_ready=1.
- Capacity: DEPTH+1 codes buffered (FIFO plus output register) before in_ready falls.
- in_ready rises the cycle after a pop from a full FIFO, never in the same cycle.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

## Test plan
- Decode sweep, out_ready=1, one code at a time:
  - 0x00 → 0x000
  - 0x2A → 0x028 (+40)
  - 0xB5 → 0xFD8 (−40)
  - 0x7F → 0x780 (+1920)
  - 0xFF → 0x880 (−1920)
  - 0x80 → 0x000
  - Each result appears 2 cycles after acceptance.
- Exhaustive: all 256 codes streamed back-to-back with out_ready=1.
  - Outputs match the reference decode in order.
  - in_ready stays 1 throughout.
  - xfer_count ends at 256.
- Backpressure, DEPTH=4, out_ready=0, in_valid held high with codes 0x01..0x06:
  - Exactly 5 accepted; in_ready=0 from the cycle after the 5th acceptance.
  - out_sample=0x001 held stable.
  - Raising out_ready drains 0x001..0x005 on consecutive cycles.
  - 0x06 is accepted the cycle after the first pop.
- Random valid/ready toggling (≥10k codes) against a scoreboard: no loss, no duplication, order preserved, xfer_count equals the scoreboard count mod 2^16.
- Reset with 3 codes buffered and out_valid=1:
  - Next cycle out_valid=0, out_sample=0x000, xfer_count=0, in_ready=1.
  - The first code after reset is the first output.
- Wrap: preload xfer_count near 0xFFFF via 65535 transfers, then 2 more transfers → xfer_count=0x0001.
